// File: rtl/lsu_mem_port_if.sv
// Request/response bundle between the MEM stage and the load/store port.
// The MEM stage is the master; lsu_mem_port is the slave.
interface lsu_mem_port_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the data port of a dual-port ram.
// One request at a time: loads are lane-extracted and sign/zero extended,
// sub-word stores are done as read-modify-write because the ram has only a
// word-wide write enable. Only DATA_WIDTH = 32 is supported.
module lsu_mem_port #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    lsu_mem_port_if.slave         bus,
    output logic                  wEn,
    output logic [ADDR_WIDTH-1:0] d_address,
    output logic [DATA_WIDTH-1:0] d_write_data,
    input  logic [DATA_WIDTH-1:0] d_read_data
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WRITE,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_RESP
    } state_e;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    state_e                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  err_q, err_d;
    // Holds the extracted load result, or the old word during read-modify-write.
    logic [DATA_WIDTH-1:0] data_q, data_d;

    logic [ADDR_WIDTH-1:0] word_addr;

    // Illegal size or an address not aligned to the access size.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            SZ_BYTE: misaligned = 1'b0;
            SZ_HALF: misaligned = lo[0];
            SZ_WORD: misaligned = |lo;
            default: misaligned = 1'b1;
        endcase
    endfunction

    // Little-endian lane extraction followed by sign or zero extension.
    function automatic logic [DATA_WIDTH-1:0] extract(input logic [DATA_WIDTH-1:0] word,
                                                      input logic [1:0] size,
                                                      input logic uns,
                                                      input logic [1:0] lane);
        logic [DATA_WIDTH-1:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_BYTE: extract = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            SZ_HALF: extract = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: extract = word;
        endcase
    endfunction

    // Replace the addressed byte or half of the old word with the store data.
    function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_word,
                                                    input logic [DATA_WIDTH-1:0] wdata,
                                                    input logic [1:0] size,
                                                    input logic [1:0] lane);
        logic [DATA_WIDTH-1:0] mask;
        logic [DATA_WIDTH-1:0] ins;
        if (size == SZ_BYTE) begin
            mask = 32'h0000_00FF << {lane, 3'b000};
            ins  = {24'h0, wdata[7:0]} << {lane, 3'b000};
        end else begin
            mask = 32'h0000_FFFF << {lane, 3'b000};
            ins  = {16'h0, wdata[15:0]} << {lane, 3'b000};
        end
        merge = (old_word & ~mask) | ins;
    endfunction

    assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    // State and request latches; synchronous active-low reset.
    always_ff @(posedge clock) begin
        // NOTE: registers take non-blocking assignments so every flop samples
        // the pre-edge values, independent of statement order.
        if (!reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic, request capture, ram-side drive and response outputs.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d       = state_q;
        we_d          = we_q;
        size_d        = size_q;
        uns_d         = uns_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        err_d         = err_q;
        data_d        = data_q;
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_rdata = '0;
        bus.rsp_err   = 1'b0;
        wEn           = 1'b0;
        d_address     = '0;
        d_write_data  = '0;

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = reset;
                if (bus.req_valid && bus.req_ready) begin
                    we_d    = bus.req_we;
                    size_d  = bus.req_size;
                    uns_d   = bus.req_unsigned;
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    err_d   = misaligned(bus.req_size, bus.req_addr[1:0]);
                    data_d  = '0;
                    if (err_d)
                        state_d = ST_RESP;
                    else if (!bus.req_we)
                        state_d = ST_LOAD;
                    else if (bus.req_size == SZ_WORD)
                        state_d = ST_WRITE;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_LOAD: begin
                d_address = word_addr;
                data_d    = extract(d_read_data, size_q, uns_q, addr_q[1:0]);
                state_d   = ST_RESP;
            end
            ST_WRITE: begin
                wEn          = 1'b1;
                d_address    = word_addr;
                d_write_data = wdata_q;
                state_d      = ST_RESP;
            end
            ST_RMW_RD: begin
                d_address = word_addr;
                data_d    = d_read_data;
                state_d   = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                wEn          = 1'b1;
                d_address    = word_addr;
                d_write_data = merge(data_q, wdata_q, size_q, addr_q[1:0]);
                state_d      = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_err   = err_q;
                bus.rsp_rdata = (we_q || err_q) ? '0 : data_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: directed scenarios followed by random
// traffic, checked against a byte-addressed memory model.
module tb_lsu_mem_port;

    logic        clock;
    logic        reset;
    logic        wEn;
    logic [15:0] d_address;
    logic [31:0] d_write_data;
    logic [31:0] d_read_data;

    lsu_mem_port_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    lsu_mem_port #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .wEn          (wEn),
        .d_address    (d_address),
        .d_write_data (d_write_data),
        .d_read_data  (d_read_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Ram model: 64 words, combinational read, write at the rising edge.
    logic [31:0] ram [0:63];
    logic        poke_en;
    logic [5:0]  poke_idx;
    logic [31:0] poke_data;
    logic        clear_en;

    assign d_read_data = ram[d_address[7:2]];

    always @(posedge clock) begin
        if (clear_en) begin
            for (int w = 0; w < 64; w++) ram[w] <= 32'h0;
        end else if (wEn) begin
            ram[d_address[7:2]] <= d_write_data;
        end else if (poke_en) begin
            ram[poke_idx] <= poke_data;
        end
    end

    // Reference memory as plain bytes.
    logic [7:0] ref_b [0:255];

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [15:0] a);
        int n;
        if (sz == 2'b11) return 1'b1;
        n = 1 << sz;
        return (int'(a) % n) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [15:0] a, input logic [1:0] sz, input logic u);
        int     n;
        longint v;
        n = 1 << sz;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_b[(int'(a[7:0]) + i) % 256]) << (8 * i);
        if (sz != 2'b10 && !u && v[8 * n - 1]) v -= (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic ref_store(input logic [15:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = 1 << sz;
        for (int i = 0; i < n; i++) ref_b[(int'(a[7:0]) + i) % 256] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    function automatic logic [31:0] ref_word(input int w);
        return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
    endfunction

    // Backdoor write of one word into both the ram and the model.
    task automatic preload(input int w, input logic [31:0] d);
        @(negedge clock);
        poke_en   = 1'b1;
        poke_idx  = 6'(w);
        poke_data = d;
        @(posedge clock);
        #1 poke_en = 1'b0;
        for (int i = 0; i < 4; i++) ref_b[4*w+i] = 8'((d >> (8 * i)) & 32'hFF);
    endtask

    task automatic drive_req(input logic we, input logic [1:0] sz, input logic u,
                             input logic [15:0] a, input logic [31:0] d);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
    endtask

    // Full transaction: wait for ready, accept, then check latency, response,
    // write-enable pulses and write address against the model.
    task automatic do_op(input string tag, input logic we, input logic [1:0] sz, input logic u,
                         input logic [15:0] a, input logic [31:0] d);
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
        int          lat;
        int          wen_cnt;
        int          n;
        logic        got;
        logic [31:0] r_data;
        logic        r_err;
        exp_err  = ref_err(sz, a);
        exp_data = (we || exp_err) ? 32'h0 : ref_load(a, sz, u);
        exp_lat  = exp_err ? 1 : ((we && sz != 2'b10) ? 3 : 2);

        @(negedge clock);
        drive_req(we, sz, u, a, d);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        check({tag, " ready"}, 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;

        lat     = 0;
        wen_cnt = 0;
        got     = 1'b0;
        r_data  = 32'hx;
        r_err   = 1'bx;
        while (!got && lat < 10) begin
            @(negedge clock);
            lat++;
            if (wEn === 1'b1) begin
                wen_cnt++;
                check({tag, " d_address"}, 32'(d_address), 32'({a[15:2], 2'b00}));
            end
            if (bus.rsp_valid === 1'b1) begin
                got    = 1'b1;
                r_data = bus.rsp_rdata;
                r_err  = bus.rsp_err;
            end
        end
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " rsp_err"}, 32'(r_err), 32'(exp_err));
        check({tag, " rsp_rdata"}, r_data, exp_data);
        check({tag, " wEn cycles"}, 32'(wen_cnt), (we && !exp_err) ? 32'h1 : 32'h0);
        if (we && !exp_err) ref_store(a, sz, d);
        @(negedge clock);
        check({tag, " rsp one cycle"}, 32'(bus.rsp_valid), 32'h0);
    endtask

    initial begin
        logic [31:0] exp_w;
        int          mism;

        reset            = 1'b0;
        poke_en          = 1'b0;
        poke_idx         = '0;
        poke_data        = '0;
        clear_en         = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = '0;
        bus.req_wdata    = '0;
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h0;

        // Reset state
        repeat (2) @(posedge clock);
        #1 clear_en = 1'b0;
        bus.req_valid = 1'b1;
        @(negedge clock);
        check("reset req_ready", 32'(bus.req_ready), 32'h0);
        check("reset rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("reset rsp_rdata", bus.rsp_rdata, 32'h0);
        check("reset rsp_err", 32'(bus.rsp_err), 32'h0);
        check("reset wEn", 32'(wEn), 32'h0);
        check("reset d_address", 32'(d_address), 32'h0);
        check("reset d_write_data", d_write_data, 32'h0);
        bus.req_valid = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;

        preload(3, 32'h8899_AABB);

        // Word store then word load
        do_op("SW 4", 1'b1, 2'b10, 1'b0, 16'd4, 32'hDEAD_BEEF);
        do_op("LW 4", 1'b0, 2'b10, 1'b0, 16'd4, 32'h0);

        // Sub-word loads with sign and zero extension
        do_op("LB 13", 1'b0, 2'b00, 1'b0, 16'd13, 32'h0);
        do_op("LBU 13", 1'b0, 2'b00, 1'b1, 16'd13, 32'h0);
        do_op("LH 14", 1'b0, 2'b01, 1'b0, 16'd14, 32'h0);
        do_op("LHU 14", 1'b0, 2'b01, 1'b1, 16'd14, 32'h0);

        // Byte store through read-modify-write
        do_op("SB 13", 1'b1, 2'b00, 1'b0, 16'd13, 32'h1234_5677);
        do_op("LW 12 after SB", 1'b0, 2'b10, 1'b0, 16'd12, 32'h0);

        // Error cases
        do_op("LW 6 err", 1'b0, 2'b10, 1'b0, 16'd6, 32'h0);
        do_op("SH 13 err", 1'b1, 2'b01, 1'b0, 16'd13, 32'hFFFF_FFFF);
        do_op("size3 err", 1'b0, 2'b11, 1'b0, 16'd0, 32'h0);

        // Back-to-back with req_valid held high
        preload(3, 32'h8899_AABB);
        @(negedge clock);
        drive_req(1'b0, 2'b10, 1'b0, 16'd12, 32'h0);
        check("b2b ready first", 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1 bus.req_addr = 16'd4;
        @(negedge clock);
        check("b2b ready in load", 32'(bus.req_ready), 32'h0);
        check("b2b no early rsp", 32'(bus.rsp_valid), 32'h0);
        @(negedge clock);
        check("b2b rsp1 valid", 32'(bus.rsp_valid), 32'h1);
        check("b2b rsp1 data", bus.rsp_rdata, ref_load(16'd12, 2'b10, 1'b0));
        check("b2b ready in resp", 32'(bus.req_ready), 32'h0);
        @(negedge clock);
        check("b2b ready after resp", 32'(bus.req_ready), 32'h1);
        check("b2b idle rsp", 32'(bus.rsp_valid), 32'h0);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        check("b2b rsp2 not yet", 32'(bus.rsp_valid), 32'h0);
        @(negedge clock);
        check("b2b rsp2 valid", 32'(bus.rsp_valid), 32'h1);
        check("b2b rsp2 data", bus.rsp_rdata, ref_load(16'd4, 2'b10, 1'b0));

        // Reset during RMW_RD: nothing written, no response
        @(negedge clock);
        drive_req(1'b1, 2'b01, 1'b0, 16'd12, 32'h0000_CAFE);
        check("rst rd ready", 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("rst rd wEn", 32'(wEn), 32'h0);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst rd idle", 32'(bus.req_ready), 32'h1);
        check("rst rd no rsp", 32'(bus.rsp_valid), 32'h0);
        check("rst rd no wEn", 32'(wEn), 32'h0);
        do_op("LW 12 after rst rd", 1'b0, 2'b10, 1'b0, 16'd12, 32'h0);

        // Reset during RMW_WR: the write still lands, no response
        @(negedge clock);
        drive_req(1'b1, 2'b01, 1'b0, 16'd14, 32'h0000_CAFE);
        check("rst wr ready", 32'(bus.req_ready), 32'h1);
        @(posedge clock);
        #1 bus.req_valid = 1'b0;
        @(negedge clock);
        check("rst wr rmw_rd wEn", 32'(wEn), 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        ref_store(16'd14, 2'b01, 32'h0000_CAFE);
        exp_w = ref_word(3);
        @(negedge clock);
        check("rst wr wEn", 32'(wEn), 32'h1);
        check("rst wr d_address", 32'(d_address), 32'd12);
        check("rst wr d_write_data", d_write_data, exp_w);
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        check("rst wr no rsp", 32'(bus.rsp_valid), 32'h0);
        check("rst wr idle", 32'(bus.req_ready), 32'h1);
        do_op("LW 12 after rst wr", 1'b0, 2'b10, 1'b0, 16'd12, 32'h0);

        // Random traffic over a small address window
        for (int k = 0; k < 150; k++) begin
            logic [1:0]  sz;
            logic [15:0] a;
            logic        we;
            logic        u;
            logic [31:0] d;
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            we = 1'($urandom_range(0, 1));
            u  = 1'($urandom_range(0, 1));
            d  = $urandom;
            do_op($sformatf("rand%0d", k), we, sz, u, a, d);
        end

        mism = 0;
        for (int w = 0; w < 64; w++) if (ram[w] !== ref_word(w)) mism++;
        check("ram image", 32'(mism), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
